// File: rtl/sensor_conditioner.sv
// sensor_conditioner: sync + debounce IR/gas/fire pins, IR edge pulse and stuck detect, latched alarms with ack
module sensor_conditioner #(
  parameter int DB_CYCLES     = 1000000,
  parameter int DB_W          = 20,
  parameter int STUCK_CYCLES  = 200000000,
  parameter int STUCK_W       = 28,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_raw,
  input  logic gas_raw,
  input  logic fire_raw,
  input  logic alarm_ack,
  output logic ir_clean,
  output logic gas_clean,
  output logic fire_clean,
  output logic ir_pulse,
  output logic ir_stuck,
  output logic gas_alarm,
  output logic fire_alarm,
  output logic alarm_any
);
  logic [2:0] s1, s2, clean;
  logic [DB_W-1:0] cnt [3];
  logic [STUCK_W-1:0] stuck_cnt, stuck_cnt_n;
  logic ir_clean_d, gas_alarm_n, fire_alarm_n;
  assign {fire_clean, gas_clean, ir_clean} = clean;
  assign ir_stuck = stuck_cnt == STUCK_W'(STUCK_CYCLES);
  always_comb begin
    stuck_cnt_n  = !ir_clean ? '0 : ir_stuck ? stuck_cnt : stuck_cnt + STUCK_W'(1);
    gas_alarm_n  = gas_clean | (gas_alarm & ~alarm_ack);
    fire_alarm_n = fire_clean | (fire_alarm & ~alarm_ack);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      clean      <= '0;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
      stuck_cnt  <= '0;
      ir_clean_d <= 1'b0;
      ir_pulse   <= 1'b0;
      gas_alarm  <= 1'b0;
      fire_alarm <= 1'b0;
      alarm_any  <= 1'b0;
    end else begin
      s1 <= {fire_raw, gas_raw, ir_raw ^ IR_ACTIVE_LOW};
      s2 <= s1;
      for (int k = 0; k < 3; k++) begin
        if (s2[k] == clean[k]) cnt[k] <= '0;
        else if (cnt[k] == DB_W'(DB_CYCLES - 1)) begin
          clean[k] <= ~clean[k];
          cnt[k]   <= '0;
        end else cnt[k] <= cnt[k] + DB_W'(1);
      end
      stuck_cnt  <= stuck_cnt_n;
      ir_clean_d <= ir_clean;
      ir_pulse   <= ir_clean & ~ir_clean_d & ~ir_stuck;
      gas_alarm  <= gas_alarm_n;
      fire_alarm <= fire_alarm_n;
      alarm_any  <= gas_alarm_n | fire_alarm_n | (stuck_cnt_n == STUCK_W'(STUCK_CYCLES));
    end
  end
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: scoreboard bench with a sample-history reference model
module tb_sensor_conditioner;
  localparam int DB = 4;
  localparam int ST = 16;
  logic clk = 1'b0;
  logic reset, ir_raw, gas_raw, fire_raw, alarm_ack;
  logic ir_clean, gas_clean, fire_clean, ir_pulse, ir_stuck, gas_alarm, fire_alarm, alarm_any;
  typedef struct packed {
    logic ir_clean, gas_clean, fire_clean, ir_pulse, ir_stuck, gas_alarm, fire_alarm, alarm_any;
  } outs_t;
  outs_t m, exp_q[$];
  bit [2:0] pipe[$];
  int run[3];
  int ir_on, n_checks, n_fail, cyc;
  bit prev_ir, ir_phase, stuck_phase, sim_phase;
  int pulses_ir, pulses_stuck, stuck_seen, sim_split;
  sensor_conditioner #(.DB_CYCLES(DB), .DB_W(3), .STUCK_CYCLES(ST), .STUCK_W(5), .IR_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .ir_raw(ir_raw), .gas_raw(gas_raw), .fire_raw(fire_raw),
    .alarm_ack(alarm_ack), .ir_clean(ir_clean), .gas_clean(gas_clean), .fire_clean(fire_clean),
    .ir_pulse(ir_pulse), .ir_stuck(ir_stuck), .gas_alarm(gas_alarm), .fire_alarm(fire_alarm),
    .alarm_any(alarm_any)
  );
  always #5 clk = ~clk;
  function automatic void model_step(input bit r, input bit [2:0] raw, input bit ack);
    outs_t old;
    bit [2:0] s, cl;
    if (!r) begin
      m = '0;
      pipe = '{3'b000, 3'b000};
      run = '{0, 0, 0};
      ir_on = 0;
      prev_ir = 1'b0;
      return;
    end
    old = m;
    s = pipe.pop_front();
    pipe.push_back(raw);
    cl = {old.fire_clean, old.gas_clean, old.ir_clean};
    for (int c = 0; c < 3; c++) begin
      run[c] = (s[c] != cl[c]) ? run[c] + 1 : 0;
      if (run[c] == DB) begin
        cl[c] = ~cl[c];
        run[c] = 0;
      end
    end
    {m.fire_clean, m.gas_clean, m.ir_clean} = cl;
    ir_on = old.ir_clean ? ir_on + 1 : 0;
    m.ir_stuck = ir_on >= ST;
    m.ir_pulse = old.ir_clean && !prev_ir && !old.ir_stuck;
    prev_ir = old.ir_clean;
    m.gas_alarm = old.gas_clean || (old.gas_alarm && !ack);
    m.fire_alarm = old.fire_clean || (old.fire_alarm && !ack);
    m.alarm_any = m.gas_alarm || m.fire_alarm || m.ir_stuck;
  endfunction
  task automatic hold(input int n, input bit r, input bit ir, input bit g, input bit f, input bit a);
    repeat (n) begin
      reset = r; ir_raw = ir; gas_raw = g; fire_raw = f; alarm_ack = a;
      model_step(r, {f, g, ~ir}, a);
      exp_q.push_back(m);
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    forever begin
      outs_t got, e;
      @(posedge clk);
      #1;
      cyc++;
      got = {ir_clean, gas_clean, fire_clean, ir_pulse, ir_stuck, gas_alarm, fire_alarm, alarm_any};
      if (ir_phase && ir_pulse) pulses_ir++;
      if (stuck_phase && ir_pulse) pulses_stuck++;
      if (stuck_phase && ir_stuck) stuck_seen = 1;
      if (sim_phase && gas_alarm != fire_alarm) sim_split++;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs cyc %0d {irc,gasc,firec,pulse,stuck,gasa,firea,any} got %b exp %b", cyc, got, e);
      end
    end
  end
  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", name, got, want);
    end
  endtask
  initial begin
    hold(3, 0, 1, 1, 1, 0);
    hold(4, 1, 1, 1, 1, 0);
    hold(1, 0, 1, 1, 1, 0);
    hold(8, 1, 1, 1, 1, 0);
    hold(10, 1, 1, 0, 0, 1);
    hold(3, 1, 1, 1, 0, 0);
    hold(6, 1, 1, 0, 0, 0);
    hold(10, 1, 1, 1, 0, 0);
    hold(8, 1, 1, 0, 0, 0);
    hold(2, 1, 1, 0, 0, 1);
    ir_phase = 1;
    repeat (3) begin
      hold(10, 1, 0, 0, 0, 0);
      hold(10, 1, 1, 0, 0, 0);
    end
    hold(8, 1, 1, 0, 0, 0);
    ir_phase = 0;
    stuck_phase = 1;
    hold(30, 1, 0, 0, 0, 0);
    hold(2, 1, 1, 0, 0, 0);
    hold(8, 1, 0, 0, 0, 0);
    hold(12, 1, 1, 0, 0, 0);
    stuck_phase = 0;
    hold(8, 1, 1, 0, 1, 0);
    hold(3, 1, 1, 0, 1, 1);
    hold(8, 1, 1, 0, 0, 0);
    hold(2, 1, 1, 0, 0, 1);
    hold(2, 0, 1, 0, 0, 0);
    sim_phase = 1;
    hold(12, 1, 1, 1, 1, 1);
    sim_phase = 0;
    for (int s = 0; s < 250; s++) begin
      bit [2:0] r;
      r = 3'($urandom);
      hold($urandom_range(1, 12), $urandom_range(0, 40) != 0, r[0], r[1], r[2], $urandom_range(0, 3) == 0);
    end
    hold(4, 1, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("ir_pulse_count", pulses_ir, 3);
    check("stuck_phase_pulses", pulses_stuck, 1);
    check("stuck_asserted", stuck_seen, 1);
    check("simultaneous_split", sim_split, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Input stage that sits directly upstream of the monitoring core, between the raw IR, gas and fire sensor pins and the alarm/counter logic. It synchronises and debounces each sensor, emits a single-cycle object-detect pulse from the IR channel, and latches gas/fire alarms until they are acknowledged. It also flags a stuck or jammed IR channel. Downstream consumers see only clean, single-clock-domain signals.

Parameters:
DB_CYCLES, 1000000, consecutive stable cycles required before a debounced output changes (10 ms at 100 MHz); minimum 2.
DB_W, 20, debounce counter width; must hold DB_CYCLES-1.
STUCK_CYCLES, 200000000, cycles ir_clean may stay active before ir_stuck asserts (2 s).
STUCK_W, 28, stuck counter width; must hold STUCK_CYCLES.
IR_ACTIVE_LOW, 1, 1 means the IR module drives 0 on detection; the raw pin is inverted before synchronisation.

Ports:
clk  input  1  system clock; sole clock domain.
reset  input  1  synchronous, active-low reset.
ir_raw  input  1  asynchronous IR sensor pin.
gas_raw  input  1  asynchronous gas sensor pin, active-high.
fire_raw  input  1  asynchronous flame sensor pin, active-high.
alarm_ack  input  1  operator acknowledge, level-sampled, clean single-clock signal.
ir_clean  output  1  debounced IR detect, active-high after polarity correction.
gas_clean  output  1  debounced gas level.
fire_clean  output  1  debounced fire level.
ir_pulse  output  1  one-cycle pulse per debounced IR rising edge.
ir_stuck  output  1  IR channel continuously active for at least STUCK_CYCLES.
gas_alarm  output  1  latched gas alarm.
fire_alarm  output  1  latched fire alarm.
alarm_any  output  1  gas_alarm OR fire_alarm OR ir_stuck, registered.

Behaviour:
- Reset: when reset=0 at a rising clk edge, all outputs, synchroniser flops, debounce counters, stuck counter and edge-delay flops are set to 0. Reset has priority over all other events and aborts any in-progress debounce or stuck count.
- Synchroniser: each raw input passes through a 2-flop chain. The IR polarity inversion is applied before the first flop. The synchronised value is s2.
- Debounce, per channel and independent: the counter clears whenever s2 equals the clean output. While s2 differs from clean, the counter increments each cycle. On the cycle the counter equals DB_CYCLES-1 and s2 still differs, clean toggles and the counter clears.
- A mismatch lasting fewer than DB_CYCLES cycles leaves clean unchanged and clears the counter. The counter never wraps.
- Debounce latency: clean changes DB_CYCLES cycles after s2 changes, which is DB_CYCLES+2 cycles after a raw edge meeting setup time.
- ir_pulse: registered as ir_clean AND NOT ir_clean_d. It is high for exactly one cycle, starting the cycle after ir_clean rises.
- ir_pulse is suppressed while ir_stuck=1.
- Stuck counter: increments while ir_clean=1 and saturates at STUCK_CYCLES. It clears to 0 on the cycle ir_clean=0.
- ir_stuck is asserted while the stuck counter equals STUCK_CYCLES. It deasserts the cycle after ir_clean falls.
- Alarm latch, per channel, priority order:
  - reset;
  - set (clean=1) gives alarm=1;
  - alarm_ack=1 and clean=0 gives alarm=0;
  - otherwise hold.
- Alarm consequences: an ack while the condition is still present is ignored, so the latch re-holds. If set and ack occur in the same cycle, set wins. Alarm rises one cycle after clean rises.
- alarm_any is registered from the next-state values, so it updates in the same cycle as the alarm flags.
- gas_alarm and fire_alarm are fully independent. Simultaneous events on both set both latches in the same cycle.

Test Plan:
- Reset with DB_CYCLES=4, STUCK_CYCLES=16: hold reset=0 for 3 cycles with all raw inputs high. All outputs are 0 during reset and the cycle after. Assert reset=0 mid-debounce: counter restarts, and clean requires a full 4 stable cycles after release.
- Glitch rejection: pulse gas_raw high for 3 cycles. gas_clean and gas_alarm stay 0. Hold gas_raw high: gas_clean=1 exactly 6 cycles after the raw edge, and gas_alarm=1 with alarm_any=1 one cycle later.
- IR pulse: IR_ACTIVE_LOW=1, drive ir_raw low for 10 cycles, then high, repeated 3 times. Exactly 3 ir_pulse cycles are produced, each one cycle wide and 7 cycles after the raw falling edge.
- Stuck IR: hold ir_raw low for 30 cycles. ir_stuck rises 16 cycles after ir_clean rises, and a re-glitch produces no ir_pulse. Release ir_raw: ir_stuck clears the cycle after ir_clean falls.
- Acknowledge rules: with fire_raw held high and fire_alarm=1, alarm_ack=1 leaves fire_alarm at 1. Drop fire_raw and wait for fire_clean=0. alarm_ack=1 then clears fire_alarm and alarm_any on the next edge.
- Simultaneous events: gas_raw and fire_raw rise together while alarm_ack is held at 1. Both alarms set in the same cycle, confirming set wins over ack.
